// File: rtl/async_fifo_pkg.sv
// Helpers shared by the read and write sides of the async FIFO.
// Pointer width stays a parameter of each block; helpers work on 32-bit values.
package async_fifo_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/rd_obuf.sv
// Small register-array FIFO that holds words returned by the RAM.
// The head entry is always visible on o_head so the consumer sees first-word-fall-through.
module rd_obuf #(
    parameter int DATA_WIDTH = 8,
    parameter int OBUF_DEPTH = 3,
    localparam int PW = $clog2(OBUF_DEPTH),
    localparam int CW = $clog2(OBUF_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [CW-1:0]         o_count
);

    logic [DATA_WIDTH-1:0] r_mem [OBUF_DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_cnt;
    logic                  w_pop;

    // Depth need not be a power of two, so indices wrap explicitly.
    function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop   = i_pop & (r_cnt != '0);
    assign o_head  = r_mem[r_head];
    assign o_count = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) r_mem[i] <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_wdata;
                r_tail        <= idx_inc(r_tail);
            end
            if (w_pop) r_head <= idx_inc(r_head);
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rptr_rd_ctrl.sv
// Read-side controller of the async FIFO: owns the read pointer, issues RAM reads
// and streams returned words to the consumer through a small output buffer.
module rptr_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int PTR_WIDTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int OBUF_DEPTH = 3,
    localparam int ADDR_WIDTH = PTR_WIDTH - 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    output logic [PTR_WIDTH-1:0]  rgray_nxt,
    output logic [PTR_WIDTH-1:0]  rptr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata_mem,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int OW = $clog2(OBUF_DEPTH + 2);

    logic [PTR_WIDTH-1:0] r_rbin;
    logic [PTR_WIDTH-1:0] r_rptr;
    logic [PTR_WIDTH-1:0] w_rbin_nxt;
    logic                 r_inflight;
    logic [CW-1:0]        w_cnt;
    logic [OW-1:0]        w_occ;
    logic                 w_pop;

    // Reads already issued count against buffer space, so rd_en never needs rready.
    assign w_occ      = OW'(w_cnt) + OW'(r_inflight);
    assign rd_en      = ~rempty & (w_occ < OW'(OBUF_DEPTH));
    assign w_rbin_nxt = r_rbin + PTR_WIDTH'(rd_en);
    assign rgray_nxt  = PTR_WIDTH'(bin2gray(32'(w_rbin_nxt)));
    assign rptr       = r_rptr;
    assign raddr      = r_rbin[ADDR_WIDTH-1:0];
    assign rvalid     = (w_cnt != '0);
    assign w_pop      = rvalid & rready;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_rbin     <= w_rbin_nxt;
            r_rptr     <= rgray_nxt;
            r_inflight <= rd_en;
        end
    end

    rd_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .OBUF_DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .i_clk   (rclk),
        .i_rst_n (rrst_n),
        .i_push  (r_inflight),
        .i_wdata (rdata_mem),
        .i_pop   (w_pop),
        .o_head  (rdata),
        .o_count (w_cnt)
    );

    a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(r_inflight && (w_occ > OW'(OBUF_DEPTH))));

endmodule

// File: tb/tb_rptr_rd_ctrl.sv
// Bench for rptr_rd_ctrl: directed phases plus random traffic against a
// queue-based model of issued-but-unconsumed reads.
module tb_rptr_rd_ctrl;

    localparam int PW = 8;
    localparam int AW = PW - 1;
    localparam int DW = 8;

    logic          rclk      = 1'b0;
    logic          rrst_n    = 1'b0;
    logic          rempty    = 1'b1;
    logic          rready    = 1'b0;
    logic [DW-1:0] rdata_mem = '0;
    logic [PW-1:0] rgray_nxt, rptr;
    logic          rd_en, rvalid;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          n_rd   = 0;
    int          n_pop  = 0;
    int unsigned rd_cnt = 0;
    int          exp_q[$];
    int          rdy_q[$];

    rptr_rd_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .OBUF_DEPTH(3)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rgray_nxt (rgray_nxt),
        .rptr      (rptr),
        .rd_en     (rd_en),
        .raddr     (raddr),
        .rdata_mem (rdata_mem),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    always #5 rclk = ~rclk;

    // RAM: word at address a holds a + A0, returned one cycle after rd_en.
    always @(posedge rclk) if (rd_en) rdata_mem <= DW'(raddr) + 8'hA0;

    function automatic int gray(input int unsigned b);
        int unsigned m;
        m = b % 256;
        return int'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input bit e, input bit r);
        bit x_rd, x_vld;
        @(negedge rclk);
        rempty = e;
        rready = r;
        #1;
        x_rd  = !e && (exp_q.size() < 3);
        x_vld = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
        chk("rd_en", 32'(rd_en), 32'(x_rd));
        chk("raddr", 32'(raddr), rd_cnt % 128);
        chk("rptr", 32'(rptr), gray(rd_cnt));
        chk("rgray_nxt", 32'(rgray_nxt), gray(rd_cnt + x_rd));
        chk("rvalid", 32'(rvalid), 32'(x_vld));
        if (x_vld) chk("rdata", 32'(rdata), exp_q[0]);
        @(posedge rclk);
        if (x_vld && r) begin
            void'(exp_q.pop_front());
            void'(rdy_q.pop_front());
            n_pop++;
        end
        if (x_rd) begin
            exp_q.push_back(int'(((rd_cnt % 128) + 32'hA0) % 256));
            rdy_q.push_back(cyc + 2);
            rd_cnt++;
            n_rd++;
        end
        cyc++;
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_rvalid"}, 32'(rvalid), 0);
        chk({tag, "_rptr"}, 32'(rptr), 0);
        chk({tag, "_raddr"}, 32'(raddr), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rdata"}, 32'(rdata), 0);
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n = 1'b0;
        rempty = 1'b1;
        #1;
        check_rst("rst_now");
        repeat (2) @(negedge rclk);
        #1;
        check_rst("rst_hold");
        exp_q.delete();
        rdy_q.delete();
        rd_cnt = 0;
        rrst_n = 1'b1;
    endtask

    initial begin
        bit          e;
        int unsigned wbin;

        repeat (3) @(negedge rclk);
        #1;
        check_rst("por");
        rrst_n = 1'b1;
        repeat (3) step(1'b1, 1'b1);

        // Empty hold
        repeat (20) step(1'b1, 1'b1);

        // Burst of 5 reads
        n_rd = 0;
        repeat (5) step(1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b1);
        chk("burst_reads", 32'(n_rd), 5);

        // Backpressure: buffer fills to 3, then drains without gaps
        n_rd = 0;
        repeat (8) step(1'b0, 1'b0);
        chk("bp_reads", 32'(n_rd), 3);
        repeat (10) step(1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b1);

        // Reset mid-burst
        repeat (4) step(1'b0, 1'b1);
        do_reset();
        repeat (3) step(1'b1, 1'b1);

        // Empty-flag emulation: writer three words ahead
        wbin  = rd_cnt + 3;
        e     = 1'b0;
        n_rd  = 0;
        n_pop = 0;
        repeat (12) begin
            step(e, 1'b1);
            e = (rd_cnt == wbin);
        end
        chk("flag_reads", 32'(n_rd), 3);
        chk("flag_words", 32'(n_pop), 3);

        // Random traffic, long enough for several pointer laps
        repeat (1500) step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
        chk("rand_laps", 32'(rd_cnt > 256), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
